// File: rtl/sipo_frame_pkg.sv
// Shared types for the SIPO frame controller.
// SIPO_FRAME_PARITY_EN adds the PARITY state (even parity bit after the data).
package sipo_frame_pkg;

  localparam int DATA_WIDTH_DEFAULT = 8;

`ifdef SIPO_FRAME_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;
`endif

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_en.sv
// Enabled serial-in/parallel-out shift register; MSB_FIRST selects which end
// the first bit ends up at after WIDTH shifts.
module sipo_shift_en #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             data,
  output logic [WIDTH-1:0] q
);

  generate
    if (WIDTH == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (en) q <= data;
      end
    end else if (MSB_FIRST != 0) begin : g_msb
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (en) q <= {q[WIDTH-2:0], data};
      end
    end else begin : g_lsb
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (en) q <= {data, q[WIDTH-1:1]};
      end
    end
  endgenerate

endmodule

// File: rtl/sipo_frame_controller.sv
// Collects DATA_WIDTH serial bits after a Start strobe and hands the frame to a
// one-entry output buffer. Define SIPO_FRAME_PARITY_EN for a trailing even-parity bit.
module sipo_frame_controller
  import sipo_frame_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int MSB_FIRST  = 1
) (
  input  logic                  Clk_In,
  input  logic                  Reset_N_In,
  input  logic                  Start_In,
  input  logic                  Bit_Valid_In,
  input  logic                  Serial_Data_In,
  input  logic                  Byte_Ready_In,
  output logic [DATA_WIDTH-1:0] Byte_Out,
  output logic                  Byte_Valid_Out,
  output logic                  Busy_Out,
  output logic                  Overrun_Out,
  output logic                  Parity_Error_Out
);

  localparam int CW = cnt_width(DATA_WIDTH);

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt;
  logic                  last_bit;
  logic                  shift_en;
  logic                  cnt_clr;
  logic                  frame_done;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] sipo;

  assign last_bit = (cnt == CW'(DATA_WIDTH - 1));

  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (Start_In) state_nxt = SHIFT;
      SHIFT: begin
        if (Start_In) state_nxt = SHIFT;
`ifdef SIPO_FRAME_PARITY_EN
        else if (Bit_Valid_In && last_bit) state_nxt = PARITY;
`else
        else if (Bit_Valid_In && last_bit) state_nxt = IDLE;
`endif
      end
`ifdef SIPO_FRAME_PARITY_EN
      PARITY: begin
        if (Start_In)          state_nxt = SHIFT;
        else if (Bit_Valid_In) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Start always wins over a data bit; in IDLE data bits are ignored.
  always_comb begin
    Busy_Out   = (state != IDLE);
    cnt_clr    = Start_In;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    case (state)
      SHIFT: begin
        shift_en = Bit_Valid_In && !Start_In;
`ifndef SIPO_FRAME_PARITY_EN
        frame_done = Bit_Valid_In && !Start_In && last_bit;
`endif
      end
`ifdef SIPO_FRAME_PARITY_EN
      PARITY: frame_done = Bit_Valid_In && !Start_In;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In)   cnt <= '0;
    else if (cnt_clr)  cnt <= '0;
    else if (shift_en) cnt <= cnt + CW'(1);
  end

  sipo_shift_en #(
    .WIDTH     (DATA_WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk   (Clk_In),
    .rst_n (Reset_N_In),
    .en    (shift_en),
    .data  (Serial_Data_In),
    .q     (sipo)
  );

  // The SIPO cannot shift during the cycle after completion, so it is still
  // stable when done_q moves it into the output buffer.
  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) done_q <= 1'b0;
    else             done_q <= frame_done;
  end

`ifdef SIPO_FRAME_PARITY_EN
  logic perr_q;

  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In)     perr_q <= 1'b0;
    else if (frame_done) perr_q <= (^sipo) ^ Serial_Data_In;
  end
`endif

  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      Byte_Out       <= '0;
      Byte_Valid_Out <= 1'b0;
      Overrun_Out    <= 1'b0;
    end else begin
      Overrun_Out <= 1'b0;
      if (done_q) begin
        if (Byte_Valid_Out && !Byte_Ready_In) begin
          Overrun_Out <= 1'b1;
        end else begin
          Byte_Out       <= sipo;
          Byte_Valid_Out <= 1'b1;
        end
      end else if (Byte_Ready_In) begin
        Byte_Valid_Out <= 1'b0;
      end
    end
  end

`ifdef SIPO_FRAME_PARITY_EN
  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In)
      Parity_Error_Out <= 1'b0;
    else if (done_q && !(Byte_Valid_Out && !Byte_Ready_In))
      Parity_Error_Out <= perr_q;
  end
`else
  assign Parity_Error_Out = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_controller.sv
// Scoreboard bench for sipo_frame_controller: frames are pushed when issued and
// popped by a monitor on every output handshake.
module tb_sipo_frame_controller;

  localparam int W = 8;
`ifdef SIPO_FRAME_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         bv = 1'b0;
  logic         sd = 1'b0;
  logic         rdy = 1'b0;
  logic [W-1:0] bout;
  logic         bvo, busy, ovr, perr;

  typedef struct packed {
    logic [W-1:0] data;
    logic         perr;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_chk = 0, n_fail = 0, n_ovr = 0, exp_ovr = 0, n_pop = 0, exp_pop = 0;

  sipo_frame_controller #(.DATA_WIDTH(W), .MSB_FIRST(1)) dut (
    .Clk_In           (clk),
    .Reset_N_In       (rst_n),
    .Start_In         (start),
    .Bit_Valid_In     (bv),
    .Serial_Data_In   (sd),
    .Byte_Ready_In    (rdy),
    .Byte_Out         (bout),
    .Byte_Valid_Out   (bvo),
    .Busy_Out         (busy),
    .Overrun_Out      (ovr),
    .Parity_Error_Out (perr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted frame must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ovr) n_ovr++;
      if (bvo && rdy) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_frame: got %0h with nothing expected at %0t", bout, $time);
        end else begin
          e = q.pop_front();
          chk("frame_data", bout, e.data);
          chk("frame_perr", perr, e.perr);
          n_pop++;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start, then the data bits first-bit-first (MSB), optional parity bit,
  // with up to maxgap idle cycles before each bit. Returns just after the
  // edge that samples the final bit.
  task automatic send_frame(input logic [W-1:0] val, input int maxgap,
                            input bit push, input logic pbit);
    logic b;
    if (push) begin
      q.push_back({val, (PAR != 0) ? ((^val) ^ pbit) : 1'b0});
      exp_pop++;
    end
    start = 1'b1; bv = 1'b1; sd = 1'b1;
    step(1);
    start = 1'b0;
    for (int i = 0; i < W + PAR; i++) begin
      b = (i == W) ? pbit : val[W-1-i];
      repeat ($urandom_range(maxgap, 0)) begin
        bv = 1'b0; sd = 1'($urandom);
        @(negedge clk); chk("busy_gap", busy, 1);
        step(1);
      end
      bv = 1'b1; sd = b;
      @(negedge clk); chk("busy_bit", busy, 1);
      step(1);
    end
    bv = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v;
    logic         p;

    // Reset state
    #12;
    chk("rst_valid", bvo, 0); chk("rst_busy", busy, 0); chk("rst_data", bout, 0);
    chk("rst_ovr", ovr, 0);   chk("rst_perr", perr, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    step(2);

    // Reset mid-frame with a held frame in the buffer
    rdy = 1'b0;
    send_frame(8'hB2, 0, 0, 1'b0);
    step(2);
    chk("held_valid", bvo, 1);
    start = 1'b1; step(1); start = 1'b0;
    bv = 1'b1; sd = 1'b1; step(3);
    chk("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", bvo, 0); chk("async_busy", busy, 0); chk("async_data", bout, 0);
    chk("async_ovr", ovr, 0);   chk("async_perr", perr, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); chk("no_start_busy", busy, 0); chk("no_start_valid", bvo, 0);
      step(1);
    end
    bv = 1'b0;

    // Basic frame with latency and clear-on-ready
    rdy = 1'b1;
    send_frame(8'hB2, 0, 1, 1'b0);
    @(negedge clk); chk("lat_not_yet", bvo, 0);
    step(1);
    @(negedge clk); chk("lat_valid", bvo, 1); chk("lat_data", bout, 8'hB2);
    step(1);
    @(negedge clk); chk("valid_cleared", bvo, 0);
    step(1);

    // Random valid gaps
    send_frame(8'hB2, 3, 1, 1'b0);
    step(3);

    // Overrun: held frame kept, second dropped
    rdy = 1'b0;
    send_frame(8'hB2, 0, 1, 1'b0);
    step(2);
    send_frame(8'h5A, 1, 0, 1'b0);
    exp_ovr++;
    step(3);
    chk("ovr_count", n_ovr, exp_ovr); chk("ovr_keep_data", bout, 8'hB2); chk("ovr_keep_valid", bvo, 1);
    rdy = 1'b1; step(1); rdy = 1'b0;
    step(2);

    // Accept and load in the same cycle
    send_frame(8'hB2, 0, 1, 1'b0);
    step(2);
    send_frame(8'h5A, 0, 1, 1'b0);
    rdy = 1'b1; step(1); rdy = 1'b0;
    @(negedge clk);
    chk("same_cycle_valid", bvo, 1); chk("same_cycle_data", bout, 8'h5A); chk("same_cycle_ovr", n_ovr, exp_ovr);
    step(1);
    rdy = 1'b1; step(2);

    // Abort partial frame with a restart
    start = 1'b1; step(1); start = 1'b0;
    bv = 1'b1; sd = 1'b0; step(3); bv = 1'b0;
    send_frame(8'hFF, 0, 1, 1'b1);
    step(3);
    chk("abort_pops", n_pop, exp_pop);

`ifdef SIPO_FRAME_PARITY_EN
    rdy = 1'b0;
    send_frame(8'hB2, 0, 1, 1'b1);
    step(2);
    chk("parity_err_set", perr, 1);
    rdy = 1'b1; step(2); rdy = 1'b0;
    send_frame(8'hB2, 0, 1, 1'b0);
    step(2);
    chk("parity_err_clr", perr, 0);
    rdy = 1'b1; step(2);
`endif

    // Random frames
    rdy = 1'b1;
    for (int k = 0; k < 16; k++) begin
      v = W'($urandom);
      p = 1'($urandom);
      send_frame(v, 2, 1, p);
      step($urandom_range(2, 0));
    end
    step(4);

    chk("all_popped", q.size(), 0);
    chk("total_pops", n_pop, exp_pop);
    chk("total_ovr", n_ovr, exp_ovr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
